// File: rtl/guard_reset_sequencer.sv
// Recovery sequencer for a misbehaving AXI slave: isolate, drain, hold the slave
// in reset, wait out a recovery interval, then clear the guards' reset requests.
module guard_reset_sequencer #(
    parameter int CntWidth      = 16,
    parameter int RecoverCycles = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                rd_reset_req_i,
    input  logic                wr_reset_req_i,
    input  logic                pending_i,
    input  logic [CntWidth-1:0] drain_budget_i,
    input  logic [CntWidth-1:0] hold_cycles_i,
    output logic                isolate_o,
    output logic                slv_reset_o,
    output logic                reset_clear_o,
    output logic                busy_o,
    output logic [1:0]          cause_o,
    output logic                drain_timeout_o,
    output logic [CntWidth-1:0] reset_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_HOLD,
        S_RECOVER,
        S_CLEAR,
        S_WAIT_ACK
    } state_t;

    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
    localparam logic [CntWidth-1:0] RecLoad = CntWidth'(RecoverCycles);

    state_t                r_state;
    logic [CntWidth-1:0]   r_cnt;
    logic                  r_isolate;
    logic                  r_slv_reset;
    logic                  r_clear;
    logic                  r_busy;
    logic [1:0]            r_cause;
    logic                  r_timeout;
    logic [CntWidth-1:0]   r_reset_count;

    logic [CntWidth-1:0]   w_drain_load;
    logic [CntWidth-1:0]   w_hold_load;
    logic                  w_cnt_last;
    logic                  w_any_req;

    // A zero budget or hold length behaves as one cycle.
    assign w_drain_load = (drain_budget_i == '0) ? CntOne : drain_budget_i;
    assign w_hold_load  = (hold_cycles_i  == '0) ? CntOne : hold_cycles_i;
    assign w_cnt_last   = (r_cnt <= CntOne);
    assign w_any_req    = rd_reset_req_i | wr_reset_req_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_isolate     <= 1'b0;
            r_slv_reset   <= 1'b0;
            r_clear       <= 1'b0;
            r_busy        <= 1'b0;
            r_cause       <= '0;
            r_timeout     <= 1'b0;
            r_reset_count <= '0;
        end else begin
            r_clear <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable_i && w_any_req) begin
                        r_state   <= S_DRAIN;
                        r_cause   <= {wr_reset_req_i, rd_reset_req_i};
                        r_timeout <= 1'b0;
                        r_cnt     <= w_drain_load;
                        r_isolate <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!pending_i || w_cnt_last) begin
                        r_state     <= S_HOLD;
                        r_timeout   <= pending_i;
                        r_cnt       <= w_hold_load;
                        r_slv_reset <= 1'b1;
                        if (r_reset_count != '1) begin
                            r_reset_count <= r_reset_count + CntOne;
                        end
                    end else begin
                        r_cnt <= r_cnt - CntOne;
                    end
                end
                S_HOLD: begin
                    if (w_cnt_last) begin
                        r_state     <= S_RECOVER;
                        r_cnt       <= RecLoad;
                        r_slv_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CntOne;
                    end
                end
                S_RECOVER: begin
                    if (w_cnt_last) begin
                        r_state <= S_CLEAR;
                        r_clear <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CntOne;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // A guard still requesting gets another clear pulse.
                    if (!w_any_req) begin
                        r_state   <= S_IDLE;
                        r_isolate <= 1'b0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_state <= S_CLEAR;
                        r_clear <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_isolate   <= 1'b0;
                    r_slv_reset <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign isolate_o       = r_isolate;
    assign slv_reset_o     = r_slv_reset;
    assign reset_clear_o   = r_clear;
    assign busy_o          = r_busy;
    assign cause_o         = r_cause;
    assign drain_timeout_o = r_timeout;
    assign reset_count_o   = r_reset_count;

endmodule

// File: tb/tb_guard_reset_sequencer.sv
// Directed bench for guard_reset_sequencer; a second 2-bit-counter instance
// exercises reset-count saturation.
module tb_guard_reset_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        rd_req;
    logic        wr_req;
    logic        pending;
    logic [15:0] budget;
    logic [15:0] hold;
    logic        isolate;
    logic        slv_reset;
    logic        clr;
    logic        busy;
    logic [1:0]  cause;
    logic        timeout;
    logic [15:0] rcount;

    logic [1:0]  s_budget;
    logic [1:0]  s_hold;
    logic        s_isolate;
    logic        s_slv_reset;
    logic        s_clr;
    logic        s_busy;
    logic [1:0]  s_cause;
    logic        s_timeout;
    logic [1:0]  s_rcount;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // {busy, isolate, slv_reset, reset_clear}
    localparam logic [3:0] P_IDLE = 4'b0000;
    localparam logic [3:0] P_ISO  = 4'b1100;
    localparam logic [3:0] P_HOLD = 4'b1110;
    localparam logic [3:0] P_CLR  = 4'b1101;

    guard_reset_sequencer #(.CntWidth(16), .RecoverCycles(2)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .rd_reset_req_i  (rd_req),
        .wr_reset_req_i  (wr_req),
        .pending_i       (pending),
        .drain_budget_i  (budget),
        .hold_cycles_i   (hold),
        .isolate_o       (isolate),
        .slv_reset_o     (slv_reset),
        .reset_clear_o   (clr),
        .busy_o          (busy),
        .cause_o         (cause),
        .drain_timeout_o (timeout),
        .reset_count_o   (rcount)
    );

    guard_reset_sequencer #(.CntWidth(2), .RecoverCycles(2)) u_sat (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .rd_reset_req_i  (rd_req),
        .wr_reset_req_i  (wr_req),
        .pending_i       (pending),
        .drain_budget_i  (s_budget),
        .hold_cycles_i   (s_hold),
        .isolate_o       (s_isolate),
        .slv_reset_o     (s_slv_reset),
        .reset_clear_o   (s_clr),
        .busy_o          (s_busy),
        .cause_o         (s_cause),
        .drain_timeout_o (s_timeout),
        .reset_count_o   (s_rcount)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] ph, input logic [1:0] ecause,
                       input logic eto);
        logic [6:0] act;
        logic [6:0] exp;
        act = {busy, isolate, slv_reset, clr, cause, timeout};
        exp = {ph, ecause, eto};
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b ({busy,iso,slv,clr,cause,to})", tag, act, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    // Acts as a guard: requests, drops one cycle after seeing the clear, waits for idle.
    task automatic run_seq(input string tag);
        logic done;
        done   = 1'b0;
        rd_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (clr) rd_req = 1'b0;
            if (!busy && !rd_req) begin
                done = 1'b1;
                break;
            end
        end
        rd_req = 1'b0;
        vectors++;
        assert (done === 1'b1) else begin
            miscompares++;
            $error("FAIL %s: observed no return to idle expected idle within 40 cycles", tag);
        end
    endtask

    initial begin
        logic [3:0] ph;
        rst      = 1'b1;
        enable   = 1'b0;
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        pending  = 1'b0;
        budget   = '0;
        hold     = '0;
        s_budget = 2'd1;
        s_hold   = 2'd1;
        step();
        step();
        rst = 1'b0;
        chk("reset_state", P_IDLE, 2'b00, 1'b0);
        chk_val("reset_count_at_reset", rcount, 16'd0);

        // Budget timeout: B=3, H=4, pending stuck high; budget change mid-drain ignored.
        enable = 1'b1; budget = 16'd3; hold = 16'd4; pending = 1'b1; rd_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c <= 3)       ph = P_ISO;
            else if (c <= 7)  ph = P_HOLD;
            else if (c <= 9)  ph = P_ISO;
            else if (c == 10) ph = P_CLR;
            else if (c == 11) ph = P_ISO;
            else              ph = P_IDLE;
            chk($sformatf("timeout_c%0d", c), ph, 2'b01, (c >= 4));
            if (c == 1) budget = 16'd100;
            if (c == 4) chk_val("timeout_count", rcount, 16'd1);
            if (c == 11) rd_req = 1'b0;
        end

        // Early drain: B=10, pending falls in cycle 2.
        budget = 16'd10; hold = 16'd1; pending = 1'b1; wr_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c <= 2)      ph = P_ISO;
            else if (c == 3) ph = P_HOLD;
            else if (c <= 5) ph = P_ISO;
            else if (c == 6) ph = P_CLR;
            else if (c == 7) ph = P_ISO;
            else             ph = P_IDLE;
            chk($sformatf("early_c%0d", c), ph, 2'b10, 1'b0);
            if (c == 2) pending = 1'b0;
            if (c == 3) chk_val("early_count", rcount, 16'd2);
            if (c == 7) wr_req = 1'b0;
        end

        // Zero budgets with pending high: one DRAIN cycle, one HOLD cycle.
        budget = 16'd0; hold = 16'd0; pending = 1'b1; rd_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 1)      ph = P_ISO;
            else if (c == 2) ph = P_HOLD;
            else if (c <= 4) ph = P_ISO;
            else if (c == 5) ph = P_CLR;
            else if (c == 6) ph = P_ISO;
            else             ph = P_IDLE;
            chk($sformatf("zero_c%0d", c), ph, 2'b01, (c >= 2));
            if (c == 6) rd_req = 1'b0;
        end
        chk_val("zero_count", rcount, 16'd3);

        // Stuck request, late wr request and enable drop mid-sequence.
        budget = 16'd5; hold = 16'd1; pending = 1'b0; rd_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 1)      ph = P_ISO;
            else if (c == 2) ph = P_HOLD;
            else if (c <= 4) ph = P_ISO;
            else if (c == 5) ph = P_CLR;
            else if (c == 6) ph = P_ISO;
            else if (c == 7) ph = P_CLR;
            else if (c == 8) ph = P_ISO;
            else             ph = P_IDLE;
            chk($sformatf("stuck_c%0d", c), ph, 2'b01, 1'b0);
            if (c == 2) begin
                wr_req = 1'b1;
                enable = 1'b0;
            end
            if (c == 7) begin
                rd_req = 1'b0;
                wr_req = 1'b0;
            end
        end
        chk_val("stuck_count", rcount, 16'd4);

        // Disabled: requests ignored in IDLE.
        rd_req = 1'b1; wr_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk($sformatf("disabled_c%0d", c), P_IDLE, 2'b01, 1'b0);
        end

        // Mid-sequence reset while in HOLD.
        enable = 1'b1; wr_req = 1'b0; budget = 16'd1; hold = 16'd10; pending = 1'b1;
        step();
        chk("midrst_drain", P_ISO, 2'b01, 1'b0);
        step();
        chk("midrst_hold1", P_HOLD, 2'b01, 1'b1);
        chk_val("midrst_count_before", rcount, 16'd5);
        step();
        chk("midrst_hold2", P_HOLD, 2'b01, 1'b1);
        rst = 1'b1; rd_req = 1'b0;
        step();
        rst = 1'b0;
        chk("midrst_after", P_IDLE, 2'b00, 1'b0);
        chk_val("midrst_count_after", rcount, 16'd0);
        step();
        chk("midrst_idle", P_IDLE, 2'b00, 1'b0);

        // Saturation on the 2-bit-counter instance.
        budget = 16'd1; hold = 16'd1; pending = 1'b0;
        for (int s = 0; s < 3; s++) run_seq($sformatf("sat_seq%0d", s));
        chk_val("sat_small_full", {14'd0, s_rcount}, 16'd3);
        chk_val("sat_main_3", rcount, 16'd3);
        for (int s = 3; s < 5; s++) run_seq($sformatf("sat_seq%0d", s));
        chk_val("sat_small_held", {14'd0, s_rcount}, 16'd3);
        chk_val("sat_main_5", rcount, 16'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/guard_reset_sequencer.md
# guard_reset_sequencer

Sequences the recovery of a misbehaving AXI slave after a read or write guard raises its latched reset request. It isolates the slave by blocking new AR/AW issue, lets outstanding transactions drain within a bounded budget, and drives the slave reset for a programmable hold time. It then waits a fixed recovery interval and pulses `reset_clear` back to the guards. It sits in the AXI monitor top level, between the read/write guards, the request-gating logic and the slave reset line.

## Interface
- `CntWidth`, 16: width of the drain/hold counters, the budget inputs and `reset_count_o`.
- `RecoverCycles`, 2: cycles spent in RECOVER after the slave reset deasserts. Must be ≥1.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous and active-high. One clock; all state is updated on the rising edge of `clk_i` only.
- `enable_i`  in  1  config enable; when low, new requests are ignored in IDLE.
- `rd_reset_req_i`  in  1  latched reset request from the read guard.
- `wr_reset_req_i`  in  1  latched reset request from the write guard.
- `pending_i`  in  1  high while any transaction to the slave is outstanding.
- `drain_budget_i`  in  CntWidth  maximum DRAIN cycles; 0 is treated as 1.
- `hold_cycles_i`  in  CntWidth  slave reset assertion length; 0 is treated as 1.
- `isolate_o`  out  1  high means block new AR/AW valid toward the slave.
- `slv_reset_o`  out  1  active-high slave reset.
- `reset_clear_o`  out  1  one-cycle clear pulse to both guards.
- `busy_o`  out  1  high in any state other than IDLE.
- `cause_o`  out  2  {wr, rd} requests latched at sequence start.
- `drain_timeout_o`  out  1  sticky flag: the last DRAIN ended on budget, not on `pending_i` low.
- `reset_count_o`  out  CntWidth  number of completed HOLD entries; saturates at all-ones.

## Operation
The FSM has six states.

- **IDLE**
  - Outputs: `isolate_o`=0, `slv_reset_o`=0.
  - If `enable_i` && (`rd_reset_req_i` || `wr_reset_req_i`):
    - go to DRAIN;
    - latch `cause_o` = {wr, rd};
    - clear `drain_timeout_o`;
    - load the counter with max(`drain_budget_i`, 1).
- **DRAIN**
  - Outputs: `isolate_o`=1.
  - If `pending_i`=0, go to HOLD.
  - Else if counter ≤1, go to HOLD and set `drain_timeout_o`.
  - Else decrement the counter.
  - On entering HOLD: load the counter with max(`hold_cycles_i`, 1) and increment `reset_count_o` (saturating).
- **HOLD**
  - Outputs: `isolate_o`=1, `slv_reset_o`=1.
  - If counter ≤1, go to RECOVER and load the counter with `RecoverCycles`.
  - Else decrement the counter.
- **RECOVER**
  - Outputs: `isolate_o`=1, `slv_reset_o`=0.
  - After `RecoverCycles` cycles, go to CLEAR.
- **CLEAR**
  - Outputs: `isolate_o`=1, `reset_clear_o`=1.
  - Go to WAIT_ACK unconditionally.
- **WAIT_ACK**
  - Outputs: `isolate_o`=1.
  - If both requests are low, go to IDLE.
  - Else go to CLEAR, which re-pulses the clear.

Rules that apply in every state:
- A request that rises or changes during the sequence (DRAIN through WAIT_ACK) does not restart the sequence and does not change `cause_o`.
- `enable_i` going low mid-sequence has no effect; the sequence always completes.
- Budget and hold inputs are sampled only when the counter is loaded; later changes do not affect the running count.
- Counters never underflow.

## Timing
- Reset: `rst_i` high at an edge forces IDLE and all outputs to 0, including `cause_o`, `drain_timeout_o` and `reset_count_o`. This applies mid-sequence as well; `slv_reset_o` and `isolate_o` drop the cycle after the reset edge.
- All outputs are registered or decoded from the state register only; there is no combinational path from input to output.
- Request-to-isolate latency: a request sampled at edge n gives `isolate_o` high and `busy_o` high from cycle n+1.
- DRAIN duration: min(first cycle with `pending_i`=0, max(B, 1)) cycles, including the entry cycle.
- HOLD duration: exactly max(H, 1) cycles.
- RECOVER duration: exactly `RecoverCycles` cycles.
- `reset_clear_o`: exactly one cycle per CLEAR visit.
- Guard handshake: a guard drops its request one cycle after seeing the clear. A normal handshake is therefore CLEAR then one WAIT_ACK cycle, then IDLE.
- `isolate_o` falls on the cycle IDLE is entered.
- Minimum sequence length with `pending_i`=0 and H=1: 1 (DRAIN) + 1 (HOLD) + `RecoverCycles` + 1 (CLEAR) + 1 (WAIT_ACK) cycles.

## Test plan
- **Budget timeout.**
  - Stimulus: `rd_reset_req_i` sampled at edge 0, B=3, H=4, `RecoverCycles`=2, `pending_i` stuck at 1; the guard drops its request at cycle 11.
  - Required:
    - DRAIN in cycles 1-3, HOLD in 4-7 with `slv_reset_o`=1, RECOVER in 8-9, `reset_clear_o`=1 in cycle 10 only, IDLE at 12;
    - `drain_timeout_o`=1, `cause_o`=01, `reset_count_o`=1.
- **Early drain.**
  - Stimulus: `wr_reset_req_i` with B=10; `pending_i` falls in cycle 2.
  - Required: HOLD starts in cycle 3, `drain_timeout_o`=0, `cause_o`=10.
- **Zero budgets.**
  - Stimulus: B=0, H=0, `pending_i`=1.
  - Required: exactly one DRAIN cycle and exactly one HOLD cycle, and `drain_timeout_o`=1.
- **Stuck request.**
  - Stimulus: the guard keeps its request high for 2 cycles after the clear.
  - Required: the FSM alternates CLEAR/WAIT_ACK, with `reset_clear_o` pulsing in alternate cycles, until the request drops; then IDLE; `reset_count_o` increments only once.
- **Disabled and saturation.**
  - Stimulus (part 1): `enable_i`=0 with a request held high.
    - Required: `busy_o` stays 0.
  - Stimulus (part 2): force `reset_count_o` to all-ones, then run a full sequence.
    - Required: `reset_count_o` stays at all-ones.
- **Mid-sequence reset.**
  - Stimulus: `rst_i` pulsed while in HOLD.
  - Required: the cycle after, `slv_reset_o`=0, `isolate_o`=0, `busy_o`=0, and all counters are 0.
